// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake bundle for alu_issue_ctrl.
//   master : request producer / response consumer
//   slave  : alu_issue_ctrl
// Request side : req_valid_i, req_ready_o, req_op_i[3:0], req_a_i[31:0], req_b_i[31:0]
// Response side: rsp_valid_o, rsp_ready_i, rsp_result_o[31:0], rsp_zero_o, rsp_ovf_o, rsp_err_o
interface alu_issue_ctrl_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  req_op_i;
    logic [31:0] req_a_i;
    logic [31:0] req_b_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_result_o;
    logic        rsp_zero_o;
    logic        rsp_ovf_o;
    logic        rsp_err_o;

    modport master (
        output req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_ovf_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_ovf_o, rsp_err_o
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequencing front-end for an external 32-bit carry-lookahead ALU.
// Accepts one request at a time, decodes the opcode into ALU control lines, drives
// registered operands, runs 1 (logic/add/sub), 2 (SLT) or 32 (shift-add MUL) ALU
// passes and returns a registered result with zero/overflow/error flags.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   bus (slave)           request/response handshake
//   alu_src1_o/alu_src2_o registered ALU operands
//   alu_less_o, alu_a_invert_o, alu_b_invert_o, alu_cin_o, alu_operation_o
//                         registered ALU controls
//   alu_result_i          combinational ALU result, sampled one edge after loading
module alu_issue_ctrl (
    input  logic                  clk_i,
    input  logic                  rst_i,
    alu_issue_ctrl_if.slave       bus,
    output logic [31:0]           alu_src1_o,
    output logic [31:0]           alu_src2_o,
    output logic                  alu_less_o,
    output logic                  alu_a_invert_o,
    output logic                  alu_b_invert_o,
    output logic                  alu_cin_o,
    output logic [1:0]            alu_operation_o,
    input  logic [31:0]           alu_result_i
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NAND = 4'b1101;

    typedef enum logic [2:0] {IDLE, EXEC, SLT1, SLT2, MUL, DONE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] src1_reg, src1_next, src2_reg, src2_next;
    logic        less_reg, less_next, ainv_reg, ainv_next, binv_reg, binv_next;
    logic        cin_reg, cin_next;
    logic [1:0]  operation_reg, operation_next;
    logic [3:0]  op_reg, op_next;
    logic [31:0] m_reg, m_next, q_reg, q_next;
    logic [4:0]  count_reg, count_next;
    logic [31:0] result_reg, result_next;
    logic        zero_reg, zero_next, ovf_reg, ovf_next, err_reg, err_next;
    logic        ready_reg, ready_next, valid_reg, valid_next;

    logic        slt_ovf, slt_set;
    logic [31:0] m_shift, q_shift;

    // SLT pass 1 runs a SUB; the sign of the true difference is diff[31] corrected by overflow.
    assign slt_ovf = (src1_reg[31] != src2_reg[31]) && (alu_result_i[31] != src1_reg[31]);
    assign slt_set = alu_result_i[31] ^ slt_ovf;
    assign m_shift = m_reg << 1;
    assign q_shift = q_reg >> 1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        src1_next      = src1_reg;
        src2_next      = src2_reg;
        less_next      = less_reg;
        ainv_next      = ainv_reg;
        binv_next      = binv_reg;
        cin_next       = cin_reg;
        operation_next = operation_reg;
        op_next        = op_reg;
        m_next         = m_reg;
        q_next         = q_reg;
        count_next     = count_reg;
        result_next    = result_reg;
        zero_next      = zero_reg;
        ovf_next       = ovf_reg;
        err_next       = err_reg;

        case (state_reg)
            IDLE: begin
                // ready_reg stays low for the first cycle out of reset, so gate on it too.
                if (bus.req_valid_i && ready_reg) begin
                    src1_next      = bus.req_a_i;
                    src2_next      = bus.req_b_i;
                    less_next      = 1'b0;
                    ainv_next      = 1'b0;
                    binv_next      = 1'b0;
                    cin_next       = 1'b0;
                    operation_next = 2'b00;
                    op_next        = bus.req_op_i;
                    state_next     = EXEC;
                    case (bus.req_op_i)
                        OP_AND:  operation_next = 2'b00;
                        OP_OR:   operation_next = 2'b01;
                        OP_ADD:  operation_next = 2'b10;
                        OP_SUB: begin
                            binv_next      = 1'b1;
                            cin_next       = 1'b1;
                            operation_next = 2'b10;
                        end
                        OP_NOR: begin
                            ainv_next      = 1'b1;
                            binv_next      = 1'b1;
                            operation_next = 2'b00;
                        end
                        OP_NAND: begin
                            ainv_next      = 1'b1;
                            binv_next      = 1'b1;
                            operation_next = 2'b01;
                        end
                        OP_SLT: begin
                            binv_next      = 1'b1;
                            cin_next       = 1'b1;
                            operation_next = 2'b10;
                            state_next     = SLT1;
                        end
                        OP_MUL: begin
                            // ALU accumulates P + (Q[0] ? M : 0) each pass.
                            src1_next      = 32'd0;
                            src2_next      = bus.req_b_i[0] ? bus.req_a_i : 32'd0;
                            operation_next = 2'b10;
                            m_next         = bus.req_a_i;
                            q_next         = bus.req_b_i;
                            count_next     = 5'd0;
                            state_next     = MUL;
                        end
                        default: begin
                            result_next = 32'd0;
                            zero_next   = 1'b1;
                            ovf_next    = 1'b0;
                            err_next    = 1'b1;
                            state_next  = DONE;
                        end
                    endcase
                end
            end
            EXEC: begin
                result_next = alu_result_i;
                zero_next   = (alu_result_i == 32'd0);
                err_next    = 1'b0;
                ovf_next    = 1'b0;
                if (op_reg == OP_ADD) begin
                    ovf_next = (src1_reg[31] == src2_reg[31]) && (alu_result_i[31] != src1_reg[31]);
                end else if (op_reg == OP_SUB) begin
                    ovf_next = (src1_reg[31] != src2_reg[31]) && (alu_result_i[31] != src1_reg[31]);
                end
                state_next = DONE;
            end
            SLT1: begin
                binv_next      = 1'b1;
                cin_next       = 1'b1;
                operation_next = 2'b11;
                less_next      = slt_set;
                state_next     = SLT2;
            end
            SLT2: begin
                result_next = alu_result_i;
                zero_next   = (alu_result_i == 32'd0);
                ovf_next    = 1'b0;
                err_next    = 1'b0;
                less_next   = 1'b0;
                state_next  = DONE;
            end
            MUL: begin
                src1_next  = alu_result_i;
                m_next     = m_shift;
                q_next     = q_shift;
                src2_next  = q_shift[0] ? m_shift : 32'd0;
                count_next = count_reg + 5'd1;
                if (count_reg == 5'd31) begin
                    result_next = alu_result_i;
                    zero_next   = (alu_result_i == 32'd0);
                    ovf_next    = 1'b0;
                    err_next    = 1'b0;
                    state_next  = DONE;
                end
            end
            DONE: begin
                if (bus.rsp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        ready_next = (state_next == IDLE);
        valid_next = (state_next == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src1_reg      <= '0;
            src2_reg      <= '0;
            less_reg      <= 1'b0;
            ainv_reg      <= 1'b0;
            binv_reg      <= 1'b0;
            cin_reg       <= 1'b0;
            operation_reg <= 2'b00;
            op_reg        <= 4'd0;
            m_reg         <= '0;
            q_reg         <= '0;
            count_reg     <= '0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            err_reg       <= 1'b0;
            ready_reg     <= 1'b0;
            valid_reg     <= 1'b0;
        end else begin
            src1_reg      <= src1_next;
            src2_reg      <= src2_next;
            less_reg      <= less_next;
            ainv_reg      <= ainv_next;
            binv_reg      <= binv_next;
            cin_reg       <= cin_next;
            operation_reg <= operation_next;
            op_reg        <= op_next;
            m_reg         <= m_next;
            q_reg         <= q_next;
            count_reg     <= count_next;
            result_reg    <= result_next;
            zero_reg      <= zero_next;
            ovf_reg       <= ovf_next;
            err_reg       <= err_next;
            ready_reg     <= ready_next;
            valid_reg     <= valid_next;
        end
    end

    assign bus.req_ready_o  = ready_reg;
    assign bus.rsp_valid_o  = valid_reg;
    assign bus.rsp_result_o = result_reg;
    assign bus.rsp_zero_o   = zero_reg;
    assign bus.rsp_ovf_o    = ovf_reg;
    assign bus.rsp_err_o    = err_reg;

    assign alu_src1_o      = src1_reg;
    assign alu_src2_o      = src2_reg;
    assign alu_less_o      = less_reg;
    assign alu_a_invert_o  = ainv_reg;
    assign alu_b_invert_o  = binv_reg;
    assign alu_cin_o       = cin_reg;
    assign alu_operation_o = operation_reg;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU attached to the ALU port,
// directed cases plus randomized requests compared against an arithmetic reference.
module tb_alu_issue_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic        alu_less, alu_ainv, alu_binv, alu_cin;
    logic [1:0]  alu_operation;

    int n_vec = 0;
    int n_err = 0;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .bus             (bus.slave),
        .alu_src1_o      (alu_src1),
        .alu_src2_o      (alu_src2),
        .alu_less_o      (alu_less),
        .alu_a_invert_o  (alu_ainv),
        .alu_b_invert_o  (alu_binv),
        .alu_cin_o       (alu_cin),
        .alu_operation_o (alu_operation),
        .alu_result_i    (alu_result)
    );

    always #5 clk_i = ~clk_i;

    // External ALU: optional inversion of each input, then AND / OR / add / less.
    logic [31:0] alu_a_m, alu_b_m;
    always_comb begin
        alu_a_m = alu_ainv ? ~alu_src1 : alu_src1;
        alu_b_m = alu_binv ? ~alu_src2 : alu_src2;
        case (alu_operation)
            2'b00:   alu_result = alu_a_m & alu_b_m;
            2'b01:   alu_result = alu_a_m | alu_b_m;
            2'b10:   alu_result = alu_a_m + alu_b_m + {31'd0, alu_cin};
            default: alu_result = {31'd0, alu_less};
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: result/flags/latency straight from the opcode semantics.
    task automatic ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] r, output logic ovf, output logic err,
                             output int lat);
        longint sa, sb, s;
        logic [63:0] prod;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ovf = 1'b0;
        err = 1'b0;
        lat = 1;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin
                r = a + b;
                s = sa + sb;
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: begin
                r = a - b;
                s = sa - sb;
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b1100: r = ~(a | b);
            4'b1101: r = ~(a & b);
            4'b0111: begin
                r = (sa < sb) ? 32'd1 : 32'd0;
                lat = 2;
            end
            4'b1000: begin
                prod = {32'd0, a} * {32'd0, b};
                r = prod[31:0];
                lat = 32;
            end
            default: begin
                r = 32'd0;
                err = 1'b1;
                lat = 0;
            end
        endcase
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        logic [31:0] exp_r;
        logic        exp_ovf, exp_err;
        int          exp_lat, lat, w;
        ref_model(op, a, b, exp_r, exp_ovf, exp_err, exp_lat);
        w = 0;
        while (!bus.req_ready_o && w < 200) begin
            @(negedge clk_i);
            w++;
        end
        chk("req_ready_before", {31'd0, bus.req_ready_o}, 32'd1);
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = op;
        bus.req_a_i     = a;
        bus.req_b_i     = b;
        @(posedge clk_i);
        @(negedge clk_i);
        // Junk request kept asserted while busy; it must be ignored.
        bus.req_op_i = 4'($urandom);
        bus.req_a_i  = $urandom;
        bus.req_b_i  = $urandom;
        lat = 0;
        while (!bus.rsp_valid_o && lat < 100) begin
            @(posedge clk_i);
            @(negedge clk_i);
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("result", bus.rsp_result_o, exp_r);
        chk("zero", {31'd0, bus.rsp_zero_o}, {31'd0, exp_r == 32'd0});
        chk("ovf", {31'd0, bus.rsp_ovf_o}, {31'd0, exp_ovf});
        chk("err", {31'd0, bus.rsp_err_o}, {31'd0, exp_err});
        chk("ready_busy", {31'd0, bus.req_ready_o}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            chk("hold_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
            chk("hold_result", bus.rsp_result_o, exp_r);
            chk("hold_err", {31'd0, bus.rsp_err_o}, {31'd0, exp_err});
            chk("hold_ready", {31'd0, bus.req_ready_o}, 32'd0);
        end
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        bus.rsp_ready_i = 1'b0;
        chk("valid_after_take", {31'd0, bus.rsp_valid_o}, 32'd0);
        chk("ready_after_take", {31'd0, bus.req_ready_o}, 32'd1);
        $display("op=%b a=%h b=%h -> result=%h zero=%b ovf=%b err=%b lat=%0d",
                 op, a, b, bus.rsp_result_o, bus.rsp_zero_o, bus.rsp_ovf_o, bus.rsp_err_o, lat);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, {31'd0, bus.req_ready_o}, 32'd0);
        chk({tag, "_valid"}, {31'd0, bus.rsp_valid_o}, 32'd0);
        chk({tag, "_result"}, bus.rsp_result_o, 32'd0);
        chk({tag, "_flags"}, {29'd0, bus.rsp_zero_o, bus.rsp_ovf_o, bus.rsp_err_o}, 32'd0);
        chk({tag, "_src1"}, alu_src1, 32'd0);
        chk({tag, "_src2"}, alu_src2, 32'd0);
        chk({tag, "_ctl"}, {26'd0, alu_less, alu_ainv, alu_binv, alu_cin, alu_operation}, 32'd0);
    endtask

    logic [3:0] legal_ops [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                                  4'b1100, 4'b1101, 4'b0111, 4'b1000};

    initial begin
        logic [3:0] op;
        rst_i           = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_op_i    = 4'd0;
        bus.req_a_i     = 32'd0;
        bus.req_b_i     = 32'd0;
        bus.rsp_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk_all_zero("reset");
        rst_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("ready_out_of_reset", {31'd0, bus.req_ready_o}, 32'd1);

        run_op(4'b0010, 32'h7FFFFFFF, 32'h00000001, 0);
        run_op(4'b0110, 32'd5, 32'd5, 1);
        run_op(4'b1100, 32'h0F0F0F0F, 32'h00FF00FF, 0);
        run_op(4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(4'b0111, 32'h80000000, 32'h00000001, 0);
        run_op(4'b0111, 32'h7FFFFFFF, 32'h80000000, 0);
        run_op(4'b1000, 32'h00012345, 32'h00010000, 0);
        run_op(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(4'b0101, 32'h12345678, 32'h9ABCDEF0, 5);
        run_op(4'b0110, 32'h80000000, 32'h00000001, 0);

        // Reset in the middle of a multiply abandons it.
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = 4'b1000;
        bus.req_a_i     = 32'h00001234;
        bus.req_b_i     = 32'h00005678;
        @(posedge clk_i);
        @(negedge clk_i);
        bus.req_valid_i = 1'b0;
        repeat (9) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        chk_all_zero("mul_reset");
        rst_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("mul_reset_no_rsp", {31'd0, bus.rsp_valid_o}, 32'd0);
        run_op(4'b0010, 32'd2, 32'd3, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) op = 4'($urandom);
            else op = legal_ops[$urandom_range(0, 7)];
            run_op(op, $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
